// File: rtl/digger_pkg.sv
// Shared constants for the digger game logic: map geometry, mover direction codes
// and the bit layout of the free_direction vector.
package digger_pkg;

  localparam int unsigned BLOCK_SHIFT = 5;
  localparam int unsigned GRID_COLS   = 20;
  localparam int unsigned GRID_ROWS   = 15;

  // Mover's 2-bit direction encoding.
  localparam logic [1:0] UP    = 2'd0;
  localparam logic [1:0] RIGHT = 2'd1;
  localparam logic [1:0] DOWN  = 2'd2;
  localparam logic [1:0] LEFT  = 2'd3;

  // Bit positions inside free_direction.
  localparam logic [1:0] FD_UP_BIT    = 2'd3;
  localparam logic [1:0] FD_RIGHT_BIT = 2'd2;
  localparam logic [1:0] FD_DOWN_BIT  = 2'd1;
  localparam logic [1:0] FD_LEFT_BIT  = 2'd0;

  localparam logic [3:0] FD_HORIZ = 4'b0101;
  localparam logic [3:0] FD_VERT  = 4'b1010;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StRdUp,
    StRdRight,
    StRdDown,
    StRdLeft,
    StWait,
    StDone
  } fd_state_e;

  function automatic logic [1:0] dir_to_bit(input logic [1:0] dir);
    logic [1:0] b;
    unique case (dir)
      UP:      b = FD_UP_BIT;
      RIGHT:   b = FD_RIGHT_BIT;
      DOWN:    b = FD_DOWN_BIT;
      default: b = FD_LEFT_BIT;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/grid_neighbor_addr.sv
// Combinational neighbour-cell lookup: returns the map address of the cell next to
// (col,row) in direction dir, plus an in-grid flag. ALIEN_FREEDIR_WRAP_EN wraps left/right.
module grid_neighbor_addr
  import digger_pkg::*;
#(
  parameter int unsigned GRID_COLS = digger_pkg::GRID_COLS,
  parameter int unsigned GRID_ROWS = digger_pkg::GRID_ROWS
) (
  input  logic [5:0] col,
  input  logic [5:0] row,
  input  logic [1:0] dir,
  output logic [8:0] addr,
  output logic       in_grid
);

  localparam logic [5:0] LastCol = 6'(GRID_COLS - 1);
  localparam logic [5:0] LastRow = 6'(GRID_ROWS - 1);
  localparam logic [8:0] ColsW   = 9'(GRID_COLS);

  logic [5:0] ncol;
  logic [5:0] nrow;

  // Range check happens here so the multiply only ever sees legal coordinates.
  always_comb begin
    ncol    = col;
    nrow    = row;
    in_grid = 1'b1;
    unique case (dir)
      UP: begin
        if (row == 6'd0) in_grid = 1'b0;
        else             nrow = row - 6'd1;
      end
      DOWN: begin
        if (row >= LastRow) in_grid = 1'b0;
        else                nrow = row + 6'd1;
      end
      RIGHT: begin
        if (col >= LastCol) begin
`ifdef ALIEN_FREEDIR_WRAP_EN
          ncol = 6'd0;
`else
          in_grid = 1'b0;
`endif
        end else begin
          ncol = col + 6'd1;
        end
      end
      default: begin
        if (col == 6'd0) begin
`ifdef ALIEN_FREEDIR_WRAP_EN
          ncol = LastCol;
`else
          in_grid = 1'b0;
`endif
        end else begin
          ncol = col - 6'd1;
        end
      end
    endcase
  end

  assign addr = in_grid ? (9'(nrow) * ColsW + 9'(ncol)) : 9'd0;

endmodule

// File: rtl/alien_free_direction.sv
// Per-frame tunnel probe producing the alien's passable-direction vector.
// Optional ALIEN_FREEDIR_WRAP_EN (in grid_neighbor_addr) wraps the horizontal map edges.
module alien_free_direction
  import digger_pkg::*;
#(
  parameter int unsigned BLOCK_SHIFT    = digger_pkg::BLOCK_SHIFT,
  parameter int unsigned GRID_COLS      = digger_pkg::GRID_COLS,
  parameter int unsigned GRID_ROWS      = digger_pkg::GRID_ROWS,
  parameter int unsigned MAP_RD_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic signed [10:0] topLeftX,
  input  logic signed [10:0] topLeftY,
  output logic               map_rd_en,
  output logic [8:0]         map_addr,
  input  logic               map_rdata,
  output logic [3:0]         free_direction,
  output logic               dir_valid,
  output logic               busy
);

  localparam int unsigned L = MAP_RD_LATENCY;
  localparam logic [10:0] AlignMask = 11'((1 << BLOCK_SHIFT) - 1);

  fd_state_e state_q, state_d;

  logic signed [10:0] x_q, y_q;
  logic [10:0]        x_cell, y_cell;
  logic               off_grid, align_x, align_y;

  logic [1:0] nb_dir;
  logic [8:0] nb_addr;
  logic       nb_in_grid;
  logic       issue;

  logic [3:0] res_q, res_d;
  logic [L:0] tag_vld_q;
  logic [1:0] tag_dir_q [L+1];
  logic       pending;

  logic [8:0] map_addr_q;
  logic [3:0] free_dir_q;
  logic       dir_valid_q;

  assign x_cell   = 11'($unsigned(x_q) >> BLOCK_SHIFT);
  assign y_cell   = 11'($unsigned(y_q) >> BLOCK_SHIFT);
  assign off_grid = x_q[10] | y_q[10] | (x_cell >= 11'(GRID_COLS)) | (y_cell >= 11'(GRID_ROWS));
  assign align_x  = ($unsigned(x_q) & AlignMask) == 11'd0;
  assign align_y  = ($unsigned(y_q) & AlignMask) == 11'd0;

  grid_neighbor_addr #(
    .GRID_COLS (GRID_COLS),
    .GRID_ROWS (GRID_ROWS)
  ) u_grid_neighbor_addr (
    .col     (x_cell[5:0]),
    .row     (y_cell[5:0]),
    .dir     (nb_dir),
    .addr    (nb_addr),
    .in_grid (nb_in_grid)
  );

  // Tag stage 0 is the registered strobe itself; stage L lines up with map_rdata.
  assign pending = |tag_vld_q[L-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Each state prepares the read that is strobed during the following state.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    issue   = 1'b0;
    nb_dir  = UP;
    unique case (state_q)
      StIdle: begin
        if (startOfFrame) state_d = StLatch;
      end
      StLatch: begin
        res_d = 4'b0000;
        if (off_grid) begin
          state_d = StDone;
        end else if (!align_x) begin
          res_d   = FD_HORIZ;
          state_d = StDone;
        end else if (!align_y) begin
          res_d   = FD_VERT;
          state_d = StDone;
        end else begin
          issue   = 1'b1;
          nb_dir  = UP;
          state_d = StRdUp;
        end
      end
      StRdUp: begin
        issue   = 1'b1;
        nb_dir  = RIGHT;
        state_d = StRdRight;
      end
      StRdRight: begin
        issue   = 1'b1;
        nb_dir  = DOWN;
        state_d = StRdDown;
      end
      StRdDown: begin
        issue   = 1'b1;
        nb_dir  = LEFT;
        state_d = StRdLeft;
      end
      StRdLeft: state_d = StWait;
      StWait: begin
        if (!pending) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (tag_vld_q[L]) res_d[dir_to_bit(tag_dir_q[L])] = map_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q         <= '0;
      y_q         <= '0;
      res_q       <= '0;
      tag_vld_q   <= '0;
      for (int k = 0; k <= L; k++) tag_dir_q[k] <= UP;
      map_addr_q  <= '0;
      free_dir_q  <= '0;
      dir_valid_q <= 1'b0;
    end else begin
      if (state_q == StIdle && startOfFrame) begin
        x_q <= topLeftX;
        y_q <= topLeftY;
      end
      res_q        <= res_d;
      tag_vld_q[0] <= issue & nb_in_grid;
      tag_dir_q[0] <= nb_dir;
      for (int k = 1; k <= L; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_dir_q[k] <= tag_dir_q[k-1];
      end
      if (issue && nb_in_grid) map_addr_q <= nb_addr;
      dir_valid_q <= (state_q == StDone);
      if (state_q == StDone) free_dir_q <= res_q;
    end
  end

  assign map_rd_en      = tag_vld_q[0];
  assign map_addr       = map_addr_q;
  assign free_direction = free_dir_q;
  assign dir_valid      = dir_valid_q;
  assign busy           = (state_q != StIdle);

endmodule
